// File: rtl/tc_pl_bus_txb_fifo_if.sv
// Producer/consumer bundle for the frame-aware chip-select buffer.
// master: the side driving writes and pops; slave: the buffer itself.
interface tc_pl_bus_txb_fifo_if #(
    parameter int unsigned AGP0_25    = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AGP0_23    = 9
);
    logic                  wr_en;
    logic [AGP0_25-1:0]    wr_data;
    logic                  wr_last;
    logic                  wr_abort;
    logic                  wr_full;
    logic                  wr_drop;
    logic [DEPTH_LOG2:0]   frm_cnt;
    logic                  txb_req;
    logic [AGP0_23-1:0]    txb_data;
    logic                  txb_empty;

    modport master (
        output wr_en, wr_data, wr_last, wr_abort, txb_req,
        input  wr_full, wr_drop, frm_cnt, txb_data, txb_empty
    );

    modport slave (
        input  wr_en, wr_data, wr_last, wr_abort, txb_req,
        output wr_full, wr_drop, frm_cnt, txb_data, txb_empty
    );
endinterface

// File: rtl/tc_pl_bus_txb_fifo.sv
// Frame-aware chip-select FIFO: words become readable only once their frame
// commits; overflowed or aborted frames are rolled back to the commit pointer.
module tc_pl_bus_txb_fifo #(
    parameter int unsigned AGP0_23    = 9,
    parameter int unsigned AGP0_25    = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic                 clk,
    input logic                 rst,
    tc_pl_bus_txb_fifo_if.slave bus
);
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    logic [AGP0_23-1:0] mem [DEPTH];

    state_t        state, state_nxt;
    logic [PW-1:0] wptr, wptr_nxt;
    logic [PW-1:0] cptr, cptr_nxt;
    logic [PW-1:0] rptr;
    logic [PW-1:0] frm_cnt;
    logic          wr_drop, drop_nxt;
    logic          mem_we;
    logic          commit;
    logic [PW-1:0] used;
    logic          full;
    logic          empty;
    logic          pop;
    logic          pop_last;
    logic [AGP0_23-1:0] head;

    assign used     = wptr - rptr;
    assign full     = (used == PW'(DEPTH));
    assign empty    = (cptr == rptr);
    assign head     = mem[rptr[DEPTH_LOG2-1:0]];
    assign pop      = bus.txb_req & ~empty;
    assign pop_last = pop & head[AGP0_23-1];

    assign bus.wr_full   = full;
    assign bus.wr_drop   = wr_drop;
    assign bus.frm_cnt   = frm_cnt;
    assign bus.txb_empty = empty;
    assign bus.txb_data  = empty ? '0 : head;

    // Write FSM next-state and pointer control; abort overrides any write.
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        cptr_nxt  = cptr;
        drop_nxt  = 1'b0;
        mem_we    = 1'b0;
        commit    = 1'b0;
        if (bus.wr_abort) begin
            wptr_nxt  = cptr;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FILL: begin
                    if (bus.wr_en) begin
                        if (full) begin
                            wptr_nxt  = cptr;
                            drop_nxt  = 1'b1;
                            state_nxt = bus.wr_last ? S_IDLE : S_DISCARD;
                        end else begin
                            mem_we   = 1'b1;
                            wptr_nxt = wptr + PW'(1);
                            if (bus.wr_last) begin
                                commit    = 1'b1;
                                cptr_nxt  = wptr + PW'(1);
                                state_nxt = S_IDLE;
                            end else begin
                                state_nxt = S_FILL;
                            end
                        end
                    end
                end
                S_DISCARD: begin
                    if (bus.wr_en && bus.wr_last) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            wptr    <= '0;
            cptr    <= '0;
            rptr    <= '0;
            frm_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            wptr    <= wptr_nxt;
            cptr    <= cptr_nxt;
            wr_drop <= drop_nxt;
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            // Commit and last-word pop on the same edge cancel out.
            if (commit && !pop_last) begin
                frm_cnt <= frm_cnt + PW'(1);
            end else if (!commit && pop_last) begin
                frm_cnt <= frm_cnt - PW'(1);
            end
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= {bus.wr_last, bus.wr_data};
        end
    end
endmodule

// File: tb/tb_tc_pl_bus_txb_fifo.sv
// Bench for tc_pl_bus_txb_fifo: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tc_pl_bus_txb_fifo;
    localparam int unsigned CW    = 8;
    localparam int unsigned DL    = 4;
    localparam int unsigned RW    = 9;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tc_pl_bus_txb_fifo_if #(.AGP0_25(CW), .DEPTH_LOG2(DL), .AGP0_23(RW)) bus ();

    tc_pl_bus_txb_fifo #(.AGP0_23(RW), .AGP0_25(CW), .DEPTH_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: readable words, the frame being built, and discard mode.
    logic [RW-1:0] committed [$];
    logic [RW-1:0] pending   [$];
    bit            discard;
    bit            exp_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_frames();
        int n = 0;
        foreach (committed[i]) if (committed[i][RW-1]) n++;
        return n;
    endfunction

    // Apply inputs over one edge, advance the model at that edge.
    task automatic step(input bit en, input logic [CW-1:0] data, input bit last,
                        input bit abort, input bit req);
        bit full;
        bit do_pop;
        bus.wr_en    = en;
        bus.wr_data  = data;
        bus.wr_last  = last;
        bus.wr_abort = abort;
        bus.txb_req  = req;
        @(posedge clk);
        if (!rst) begin
            committed.delete();
            pending.delete();
            discard  = 1'b0;
            exp_drop = 1'b0;
        end else begin
            full     = (committed.size() + pending.size()) == DEPTH;
            do_pop   = req && (committed.size() > 0);
            exp_drop = 1'b0;
            if (do_pop) void'(committed.pop_front());
            if (abort) begin
                pending.delete();
                discard = 1'b0;
            end else if (en) begin
                if (discard) begin
                    if (last) discard = 1'b0;
                end else if (full) begin
                    pending.delete();
                    exp_drop = 1'b1;
                    discard  = !last;
                end else begin
                    pending.push_back({last, data});
                    if (last) begin
                        foreach (pending[i]) committed.push_back(pending[i]);
                        pending.delete();
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("txb_empty", 32'(bus.txb_empty), 32'(committed.size() == 0));
            chk("txb_data", 32'(bus.txb_data),
                (committed.size() == 0) ? 32'd0 : 32'(committed[0]));
            chk("wr_full", 32'(bus.wr_full),
                32'((committed.size() + pending.size()) == DEPTH));
            chk("frm_cnt", 32'(bus.frm_cnt), 32'(exp_frames()));
            chk("wr_drop", 32'(bus.wr_drop), 32'(exp_drop));
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        idle();
        rst = 1'b1;
        chk_en = 1'b1;
        chk("rst_empty", 32'(bus.txb_empty), 32'd1);
        chk("rst_data", 32'(bus.txb_data), 32'd0);
        chk("rst_full", 32'(bus.wr_full), 32'd0);
        chk("rst_frm", 32'(bus.frm_cnt), 32'd0);
        chk("rst_drop", 32'(bus.wr_drop), 32'd0);

        // Basic frame
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("basic_empty1", 32'(bus.txb_empty), 32'd1);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("basic_empty2", 32'(bus.txb_empty), 32'd1);
        step(1'b1, 8'h84, 1'b1, 1'b0, 1'b0);
        chk("basic_empty3", 32'(bus.txb_empty), 32'd0);
        chk("basic_frm", 32'(bus.frm_cnt), 32'd1);
        chk("basic_d0", 32'(bus.txb_data), 32'h001);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("basic_d1", 32'(bus.txb_data), 32'h002);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("basic_d2", 32'(bus.txb_data), 32'h184);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("basic_done_empty", 32'(bus.txb_empty), 32'd1);
        chk("basic_done_data", 32'(bus.txb_data), 32'd0);
        chk("basic_done_frm", 32'(bus.frm_cnt), 32'd0);

        // Partial frame then abort
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        chk("abort_empty", 32'(bus.txb_empty), 32'd1);
        step(1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("abort_data", 32'(bus.txb_data), 32'h155);
        chk("abort_frm", 32'(bus.frm_cnt), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("abort_drained", 32'(bus.txb_empty), 32'd1);

        // Overflow: 10-word frame committed, then an 8-word frame that overflows
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), i == 10, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        chk("ovf_full", 32'(bus.wr_full), 32'd1);
        step(1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
        chk("ovf_drop", 32'(bus.wr_drop), 32'd1);
        chk("ovf_full_after", 32'(bus.wr_full), 32'd0);
        step(1'b1, 8'h48, 1'b1, 1'b0, 1'b0);
        chk("ovf_drop_once", 32'(bus.wr_drop), 32'd0);
        chk("ovf_frm", 32'(bus.frm_cnt), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            chk("ovf_read", 32'(bus.txb_data), (i == 10) ? 32'h10A : 32'(i));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("ovf_drained", 32'(bus.txb_empty), 32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("ovf_recover", 32'(bus.txb_data), 32'h177);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous commit and last-word pop
        step(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
        chk("sim_frm", 32'(bus.frm_cnt), 32'd1);
        chk("sim_data", 32'(bus.txb_data), 32'h122);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(8'h60 + i), i == 5, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h67, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 8'h68, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("mrst_empty", 32'(bus.txb_empty), 32'd1);
        chk("mrst_frm", 32'(bus.frm_cnt), 32'd0);
        chk("mrst_data", 32'(bus.txb_data), 32'd0);
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
        chk("mrst_d0", 32'(bus.txb_data), 32'h031);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mrst_d1", 32'(bus.txb_data), 32'h132);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Wrap-around streaming
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0);
        end
        rst = 1'b1;

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
